// File: rtl/register_file.sv
// Architectural register file with per-entry ROB rename tags and combinational operand read/bypass.
// Reads are zero-latency; commits land in storage on the next edge; rdy=0 freezes all state.
module register_file #(
  parameter int ROB_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                commit_en,
  input  logic [4:0]          commit_reg,
  input  logic [31:0]         commit_val,
  input  logic [ROB_BITS-1:0] commit_rob_id,
  input  logic                dep_en,
  input  logic [4:0]          dep_reg,
  input  logic [ROB_BITS-1:0] dep_rob_id,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic [ROB_BITS-1:0] rob_qid1,
  output logic [ROB_BITS-1:0] rob_qid2,
  input  logic                rob_q1_ready,
  input  logic [31:0]         rob_q1_val,
  input  logic                rob_q2_ready,
  input  logic [31:0]         rob_q2_val,
  output logic [31:0]         val1,
  output logic                has_dep1,
  output logic [ROB_BITS-1:0] dep1,
  output logic [31:0]         val2,
  output logic                has_dep2,
  output logic [ROB_BITS-1:0] dep2
);

  logic [31:0]         val_q [32];
  logic [31:0]         val_d [32];
  logic [ROB_BITS-1:0] tag_q [32];
  logic [ROB_BITS-1:0] tag_d [32];
  logic [31:0]         dep_vld_q;
  logic [31:0]         dep_vld_d;

  logic                commit_live;

  assign commit_live = rdy && !clear && commit_en;

  // Rename is applied after commit so it wins when both hit the same entry.
  always_comb begin
    val_d     = val_q;
    tag_d     = tag_q;
    dep_vld_d = dep_vld_q;
    if (rdy) begin
      if (clear) begin
        dep_vld_d = '0;
      end else begin
        if (commit_en && commit_reg != 5'd0) begin
          val_d[commit_reg] = commit_val;
          if (dep_vld_q[commit_reg] && tag_q[commit_reg] == commit_rob_id)
            dep_vld_d[commit_reg] = 1'b0;
        end
        if (dep_en && dep_reg != 5'd0) begin
          dep_vld_d[dep_reg] = 1'b1;
          tag_d[dep_reg]     = dep_rob_id;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q     <= '{default: '0};
      tag_q     <= '{default: '0};
      dep_vld_q <= '0;
    end else begin
      val_q     <= val_d;
      tag_q     <= tag_d;
      dep_vld_q <= dep_vld_d;
    end
  end

  logic [4:0]          rs       [2];
  logic                q_ready  [2];
  logic [31:0]         q_val    [2];
  logic [31:0]         rd_val   [2];
  logic                rd_has   [2];
  logic [ROB_BITS-1:0] rd_dep   [2];
  logic [ROB_BITS-1:0] rd_qid   [2];

  assign rs[0]      = rs1;
  assign rs[1]      = rs2;
  assign q_ready[0] = rob_q1_ready;
  assign q_ready[1] = rob_q2_ready;
  assign q_val[0]   = rob_q1_val;
  assign q_val[1]   = rob_q2_val;

  // Operand resolution: storage, then same-cycle commit bypass, then ROB forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_qid[p] = tag_q[rs[p]];
      rd_val[p] = '0;
      rd_has[p] = 1'b0;
      rd_dep[p] = '0;
      if (rs[p] == 5'd0) begin
        rd_val[p] = '0;
      end else if (!dep_vld_q[rs[p]]) begin
        rd_val[p] = val_q[rs[p]];
      end else if (commit_live && commit_reg == rs[p] && commit_rob_id == tag_q[rs[p]]) begin
        rd_val[p] = commit_val;
      end else if (q_ready[p]) begin
        rd_val[p] = q_val[p];
      end else begin
        rd_has[p] = 1'b1;
        rd_dep[p] = tag_q[rs[p]];
      end
    end
  end

  assign rob_qid1 = rd_qid[0];
  assign rob_qid2 = rd_qid[1];
  assign val1     = rd_val[0];
  assign has_dep1 = rd_has[0];
  assign dep1     = rd_dep[0];
  assign val2     = rd_val[1];
  assign has_dep2 = rd_has[1];
  assign dep2     = rd_dep[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: rename, commit bypass, flush, x0 and async reset behaviour.
module tb_register_file;

  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic          commit_en;
  logic [4:0]    commit_reg;
  logic [31:0]   commit_val;
  logic [RB-1:0] commit_rob_id;
  logic          dep_en;
  logic [4:0]    dep_reg;
  logic [RB-1:0] dep_rob_id;
  logic [4:0]    rs1, rs2;
  logic [RB-1:0] rob_qid1, rob_qid2;
  logic          rob_q1_ready, rob_q2_ready;
  logic [31:0]   rob_q1_val, rob_q2_val;
  logic [31:0]   val1, val2;
  logic          has_dep1, has_dep2;
  logic [RB-1:0] dep1, dep2;

  int n_chk  = 0;
  int n_fail = 0;

  register_file #(.ROB_BITS(RB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id),
    .dep_en(dep_en), .dep_reg(dep_reg), .dep_rob_id(dep_rob_id),
    .rs1(rs1), .rs2(rs2),
    .rob_qid1(rob_qid1), .rob_qid2(rob_qid2),
    .rob_q1_ready(rob_q1_ready), .rob_q1_val(rob_q1_val),
    .rob_q2_ready(rob_q2_ready), .rob_q2_val(rob_q2_val),
    .val1(val1), .has_dep1(has_dep1), .dep1(dep1),
    .val2(val2), .has_dep2(has_dep2), .dep2(dep2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    commit_en = 1'b0; dep_en = 1'b0; clear = 1'b0;
  endtask

  task automatic rename(input logic [4:0] r, input logic [RB-1:0] t);
    dep_en = 1'b1; dep_reg = r; dep_rob_id = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RB-1:0] t);
    commit_en = 1'b1; commit_reg = r; commit_val = v; commit_rob_id = t;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    commit_en = 1'b0; commit_reg = '0; commit_val = '0; commit_rob_id = '0;
    dep_en = 1'b0; dep_reg = '0; dep_rob_id = '0;
    rs1 = 5'd5; rs2 = 5'd0;
    rob_q1_ready = 1'b0; rob_q1_val = '0; rob_q2_ready = 1'b0; rob_q2_val = '0;
    #2;
    chk("rst_val1", val1, 32'h0);
    chk("rst_has1", {31'b0, has_dep1}, 32'h0);
    chk("rst_qid1", {29'b0, rob_qid1}, 32'h0);
    chk("rst_val2", val2, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Rename x5 -> 3; same-cycle read still sees pre-rename state.
    rename(5'd5, 3'd3);
    #1 chk("ren_same_cycle_has1", {31'b0, has_dep1}, 32'h0);
    tick(); idle();
    chk("ren_has1", {31'b0, has_dep1}, 32'h1);
    chk("ren_dep1", {29'b0, dep1}, 32'h3);
    chk("ren_val1", val1, 32'h0);
    chk("ren_qid1", {29'b0, rob_qid1}, 32'h3);

    // ROB forwarding.
    rob_q1_ready = 1'b1; rob_q1_val = 32'hAAAA5555;
    #1 chk("fwd_val1", val1, 32'hAAAA5555);
    chk("fwd_has1", {31'b0, has_dep1}, 32'h0);
    chk("fwd_dep1", {29'b0, dep1}, 32'h0);
    rob_q1_ready = 1'b0;

    // Commit x5=0x1234 with matching tag: bypass then storage.
    commit(5'd5, 32'h1234, 3'd3);
    #1 chk("byp_val1", val1, 32'h1234);
    chk("byp_has1", {31'b0, has_dep1}, 32'h0);
    tick(); idle();
    chk("cmt_val1", val1, 32'h1234);
    chk("cmt_has1", {31'b0, has_dep1}, 32'h0);

    // Stale commit tag leaves newer rename in place.
    rename(5'd5, 3'd4);
    tick(); idle();
    commit(5'd5, 32'h5678, 3'd3);
    #1 chk("stale_same_has1", {31'b0, has_dep1}, 32'h1);
    chk("stale_same_val1", val1, 32'h0);
    tick(); idle();
    chk("stale_has1", {31'b0, has_dep1}, 32'h1);
    chk("stale_dep1", {29'b0, dep1}, 32'h4);

    // Commit and rename of x7 in one cycle: rename wins.
    rs2 = 5'd7;
    rename(5'd7, 3'd2);
    tick(); idle();
    commit(5'd7, 32'h77, 3'd2);
    rename(5'd7, 3'd6);
    #1 chk("race_byp_val2", val2, 32'h77);
    chk("race_byp_has2", {31'b0, has_dep2}, 32'h0);
    tick(); idle();
    chk("race_has2", {31'b0, has_dep2}, 32'h1);
    chk("race_dep2", {29'b0, dep2}, 32'h6);
    chk("race_val2", val2, 32'h0);

    // Rename x1..x3, then flush with a concurrent commit and rename.
    rename(5'd1, 3'd1); tick();
    rename(5'd2, 3'd2); tick();
    rename(5'd3, 3'd5); tick(); idle();
    clear = 1'b1;
    commit(5'd1, 32'hDEAD, 3'd1);
    rename(5'd2, 3'd7);
    tick(); idle();
    rs1 = 5'd1; rs2 = 5'd2;
    #1 chk("clr_val_x1", val1, 32'h0);
    chk("clr_has_x1", {31'b0, has_dep1}, 32'h0);
    chk("clr_has_x2", {31'b0, has_dep2}, 32'h0);
    rs1 = 5'd3; rs2 = 5'd5;
    #1 chk("clr_has_x3", {31'b0, has_dep1}, 32'h0);
    chk("clr_val_x5", val2, 32'h5678);
    chk("clr_has_x5", {31'b0, has_dep2}, 32'h0);
    rs2 = 5'd7;
    #1 chk("clr_val_x7", val2, 32'h77);

    // x0 ignores commit and rename.
    rs1 = 5'd0;
    rename(5'd0, 3'd3);
    commit(5'd0, 32'hFFFF_FFFF, 3'd3);
    #1 chk("x0_same_val1", val1, 32'h0);
    tick(); idle();
    chk("x0_val1", val1, 32'h0);
    chk("x0_has1", {31'b0, has_dep1}, 32'h0);
    chk("x0_qid1", {29'b0, rob_qid1}, 32'h0);

    // Commit to an undepended register reaches storage next cycle.
    rs1 = 5'd9;
    commit(5'd9, 32'h99, 3'd0);
    tick(); idle();
    chk("plain_cmt_val1", val1, 32'h99);

    // rdy=0 freezes state.
    rename(5'd9, 3'd5);
    tick(); idle();
    rdy = 1'b0; rs2 = 5'd11;
    commit(5'd9, 32'hBAD, 3'd5);
    #1 chk("hold_same_has1", {31'b0, has_dep1}, 32'h1);
    tick();
    chk("hold_has1", {31'b0, has_dep1}, 32'h1);
    chk("hold_dep1", {29'b0, dep1}, 32'h5);
    commit(5'd11, 32'h1, 3'd0);
    rename(5'd11, 3'd1);
    tick();
    chk("hold_val2", val2, 32'h0);
    chk("hold_has2", {31'b0, has_dep2}, 32'h0);

    // Asynchronous reset mid-cycle with rdy low.
    rs2 = 5'd5;
    #2 rst = 1'b1;
    #1 chk("arst_has1", {31'b0, has_dep1}, 32'h0);
    chk("arst_val1", val1, 32'h0);
    chk("arst_qid1", {29'b0, rob_qid1}, 32'h0);
    chk("arst_val2", val2, 32'h0);
    idle();
    rst = 1'b0; rdy = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_BITS, default 3, meaning ROB tag width (ROB holds 2^ROB_BITS entries).
REQ-002 SHALL have ports clk (in, 1), the single clock, and rst (in, 1), the reset. Reset is asynchronous and active-high.
REQ-003 SHALL have port rdy (in, 1): global enable. While low, no state changes.
REQ-004 SHALL have port clear (in, 1): pipeline flush from ROB.
REQ-005 SHALL have commit ports commit_en (in, 1), commit_reg (in, 5), commit_val (in, 32) and commit_rob_id (in, ROB_BITS).
REQ-006 SHALL have rename ports dep_en (in, 1), dep_reg (in, 5) and dep_rob_id (in, ROB_BITS).
REQ-007 SHALL have decoder read ports rs1 (in, 5) and rs2 (in, 5).
REQ-008 SHALL have ROB query ports rob_qid1 (out, ROB_BITS) and rob_qid2 (out, ROB_BITS).
REQ-009 SHALL have ROB reply ports rob_q1_ready (in, 1), rob_q1_val (in, 32), rob_q2_ready (in, 1) and rob_q2_val (in, 32).
REQ-010 SHALL have read results val1 (out, 32), has_dep1 (out, 1) and dep1 (out, ROB_BITS), plus val2, has_dep2 and dep2 with the same widths.

Function
REQ-011 SHALL hold 32 entries. Each entry is a 32-bit value, a dep_valid bit and a ROB_BITS tag.
REQ-012 x0 SHALL always read value 0 with no dependency. Commits and renames targeting x0 SHALL be ignored.
REQ-013 On posedge clk with rdy=1, clear=0 and commit_en=1, the register value at commit_reg SHALL be set to commit_val.
- In the same case, the entry's dep_valid SHALL be cleared only if it is set and its tag equals commit_rob_id.
REQ-014 On posedge clk with rdy=1, clear=0 and dep_en=1, the entry at dep_reg SHALL get dep_valid=1 and tag=dep_rob_id.
REQ-015 If a commit and a rename target the same register in one cycle:
- the value SHALL be written;
- the rename SHALL win: dep_valid=1, tag=dep_rob_id.
REQ-016 On posedge clk with rdy=1 and clear=1:
- every dep_valid SHALL clear;
- register values SHALL be retained;
- commit_en and dep_en SHALL be ignored that cycle.
REQ-017 rob_qidN SHALL combinationally equal the stored tag of rsN.
REQ-018 Read outputs SHALL be combinational, resolved in this priority order:
- (a) rsN=0 -> value 0, no dependency;
- (b) dep_valid clear -> stored value, no dependency;
- (c) commit_en, rdy and !clear, with commit_reg=rsN and commit_rob_id=tag -> commit_val, no dependency;
- (d) rob_qN_ready=1 -> rob_qN_val, no dependency;
- (e) otherwise has_depN=1, depN=tag, valN=0.
REQ-019 Reads SHALL NOT observe a rename issued in the same cycle; they return pre-rename state.
REQ-020 When has_depN=0, depN SHALL be 0.
REQ-021 Latency: a commit SHALL be visible in reads the same cycle via the REQ-018(c) bypass, and from storage on the next cycle.

Reset
REQ-022 While rst=1, asynchronously, all values SHALL be 0 and all dep_valid and tags SHALL be 0.
REQ-023 Reset SHALL take precedence over rdy and clear.
REQ-024 Mid-operation reset SHALL discard in-flight commit and rename.
REQ-025 Outputs after reset: every read returns value 0 with has_dep=0; rob_qid outputs are 0.

Verification
REQ-026 Rename x5 to tag 3, then read rs1=5 with rob_q1_ready=0 -> has_dep1=1, dep1=3, val1=0.
REQ-027 With x5 tagged 3, commit x5=0x1234 with commit_rob_id=3 -> the same cycle reads val1=0x1234, has_dep1=0; the next cycle the stored value is 0x1234 and dep is cleared.
REQ-028 With x5 tagged 4, commit x5 with tag 3 -> value stored, has_dep stays 1 with dep=4.
REQ-029 In one cycle, commit x7 with tag 2 (its current tag) and rename x7 to tag 6 -> next cycle has_dep=1, dep=6, stored value updated.
REQ-030 With x1, x2 and x3 renamed, assert clear=1 with commit_en=1 on x1 -> all has_dep=0, x1 value unchanged. Separately, dep_en/commit_en on x0 -> x0 still reads 0 with no dependency.
REQ-031 Assert rst mid-stream with rdy=0 -> all deps cleared and values 0 immediately, without waiting for a clock edge. While rdy=0, a commit causes no state change.
